// File: rtl/unaligned_mem_ctrl_pkg.sv
// Shared constants for the unaligned memory controller: FSM encoding and
// the mask that turns any byte address into its containing even word address.
package unaligned_mem_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD0  = 3'd1,
    ST_RD1  = 3'd2,
    ST_WR0  = 3'd3,
    ST_WR1  = 3'd4,
    ST_RESP = 3'd5
  } state_t;

  localparam logic [15:0] ALIGN_MASK = 16'hFFFE;
  localparam logic [15:0] WORD_STEP  = 16'd2;

endpackage

// File: rtl/unaligned_mem_ctrl_if.sv
// CPU request/response and memory-side bus of the unaligned memory controller,
// plus the FSM state as a debug observation point.
interface unaligned_mem_ctrl_if;
  import unaligned_mem_ctrl_pkg::*;

  // Handshake: a request transfers on a rising edge where req_valid & req_ready;
  // req_ready is only high in IDLE. resp_valid is a single-cycle pulse with
  // resp_rdata/resp_err valid in that cycle; there is no response back-pressure.
  logic        req_valid;
  logic        req_wr;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic        resp_err;
  logic        mem_enable;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_data_in;
  logic [15:0] mem_data_out;
  logic        mem_err;
  state_t      dbg_state;

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, mem_data_out, mem_err,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_enable, mem_wr, mem_addr, mem_data_in, dbg_state
  );

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, mem_data_out, mem_err,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_enable, mem_wr, mem_addr, mem_data_in, dbg_state
  );

endinterface

// File: rtl/unaligned_mem_ctrl_align_merge.sv
// Byte steering between big-endian 16-bit memory words and an odd-aligned
// CPU halfword: load merge and the two read-modify-write store words.
module align_merge (
  input  logic [15:0] w0,
  input  logic [15:0] w1,
  input  logic [15:0] wdata,
  input  logic        a0,
  output logic [15:0] load_data,
  output logic [15:0] store_word0,
  output logic [15:0] store_word1
);

  always_comb begin
    load_data   = w0;
    store_word0 = wdata;
    store_word1 = wdata;
    if (a0) begin
      load_data   = {w0[7:0], w1[15:8]};
      store_word0 = {w0[15:8], wdata[15:8]};
      store_word1 = {wdata[7:0], w1[7:0]};
    end
  end

endmodule

// File: rtl/unaligned_mem_ctrl.sv
// Controller that turns byte-aligned 16-bit CPU loads/stores into one or two
// even-address memory word accesses, with read-modify-write for odd stores.
module unaligned_mem_ctrl
  import unaligned_mem_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  unaligned_mem_ctrl_if.slave   bus
);

  state_t      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic        wr_q, wr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] w0_q, w0_d;
  logic [15:0] w1_q, w1_d;
  logic        err_q, err_d;
  logic [15:0] rdata_q, rdata_d;

  logic        accept;
  logic        a0;
  logic [15:0] base_addr;
  logic [15:0] load_data;
  logic [15:0] store_word0;
  logic [15:0] store_word1;
  logic [15:0] resp_word;

  assign a0        = addr_q[0];
  assign base_addr = addr_q & ALIGN_MASK;
  assign accept    = bus.req_valid & bus.req_ready;
  assign resp_word = wr_q ? 16'h0000 : load_data;

  align_merge u_align_merge (
    .w0          (w0_q),
    .w1          (w1_q),
    .wdata       (wdata_q),
    .a0          (a0),
    .load_data   (load_data),
    .store_word0 (store_word0),
    .store_word1 (store_word1)
  );

  always_comb begin
    state_d         = state_q;
    bus.mem_enable  = 1'b0;
    bus.mem_wr      = 1'b0;
    bus.mem_addr    = 16'h0000;
    bus.mem_data_in = 16'h0000;
    bus.resp_valid  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Only an aligned store can skip the read phase.
        if (accept) state_d = (bus.req_wr && !bus.req_addr[0]) ? ST_WR0 : ST_RD0;
      end
      ST_RD0: begin
        bus.mem_enable = 1'b1;
        bus.mem_addr   = base_addr;
        state_d        = a0 ? ST_RD1 : ST_RESP;
      end
      ST_RD1: begin
        bus.mem_enable = 1'b1;
        bus.mem_addr   = base_addr + WORD_STEP;
        state_d        = wr_q ? ST_WR0 : ST_RESP;
      end
      ST_WR0: begin
        bus.mem_enable  = 1'b1;
        bus.mem_wr      = 1'b1;
        bus.mem_addr    = base_addr;
        bus.mem_data_in = store_word0;
        state_d         = a0 ? ST_WR1 : ST_RESP;
      end
      ST_WR1: begin
        bus.mem_enable  = 1'b1;
        bus.mem_wr      = 1'b1;
        bus.mem_addr    = base_addr + WORD_STEP;
        bus.mem_data_in = store_word1;
        state_d         = ST_RESP;
      end
      ST_RESP: begin
        bus.resp_valid = 1'b1;
        state_d        = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    addr_d  = accept ? bus.req_addr  : addr_q;
    wr_d    = accept ? bus.req_wr    : wr_q;
    wdata_d = accept ? bus.req_wdata : wdata_q;
    w0_d    = (state_q == ST_RD0) ? bus.mem_data_out : w0_q;
    w1_d    = (state_q == ST_RD1) ? bus.mem_data_out : w1_q;
    err_d   = accept ? 1'b0 : (err_q | (bus.mem_enable & bus.mem_err));
    rdata_d = (state_q == ST_RESP) ? resp_word : rdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= 16'h0000;
      wr_q    <= 1'b0;
      wdata_q <= 16'h0000;
      w0_q    <= 16'h0000;
      w1_q    <= 16'h0000;
      err_q   <= 1'b0;
      rdata_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      w0_q    <= w0_d;
      w1_q    <= w1_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Response data is live during RESP and then held from the register.
  assign bus.req_ready  = (state_q == ST_IDLE) & ~rst;
  assign bus.resp_rdata = (state_q == ST_RESP) ? resp_word : rdata_q;
  assign bus.resp_err   = (state_q == ST_RESP) & err_q;
  assign bus.dbg_state  = state_q;

endmodule
